uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one UART transmitter (Tx_DATA/Tx_WR/Tx_EN/baud_select/Tx_BUSY)

---
 rtl/uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler that shares one UART transmitter among NREQ byte
//   requesters. A winner keeps the link for a burst that ends on req_last, on
//   MAX_BURST bytes, or when it stops requesting. Baud and enable settings are
//   copied to the transmitter only while idle, so a burst never sees a change.
//   A transmitter that does not raise Tx_BUSY within TIMEOUT cycles of a write
//   sets the sticky timeout_err and the grant is released.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req/req_data/req_last per-requester level request, byte [8i+7:8i], last flag
//   ack                   one-hot 1-cycle pulse when requester i's byte is taken
//   grant                 one-hot, held for the whole burst of the owner
//   baud_cfg, tx_en_cfg   requested baud code / transmitter enable
//   Tx_DATA, Tx_WR        byte and 1-cycle write strobe to the transmitter
//   Tx_EN, baud_select    transmitter enable and baud code
//   Tx_BUSY               transmitter frame in progress
//   timeout_err           sticky: Tx_BUSY never rose after a write
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  input  logic [2:0]        baud_cfg,
  input  logic              tx_en_cfg,
  output logic [7:0]        Tx_DATA,
  output logic              Tx_WR,
  output logic              Tx_EN,
  output logic [2:0]        baud_select,
  input  logic              Tx_BUSY,
  output logic              timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [PW-1:0]     ptr_r, ptr_nxt_s;
  logic [PW-1:0]     winner_r, winner_nxt_s;
  logic [7:0]        cnt_r, cnt_nxt_s;
  logic [TW-1:0]     timer_r, timer_nxt_s;
  logic              last_r, last_nxt_s;
  logic [NREQ-1:0]   ack_r, ack_nxt_s;
  logic [NREQ-1:0]   grant_r, grant_nxt_s;
  logic [7:0]        tx_data_r, tx_data_nxt_s;
  logic              tx_wr_r, tx_wr_nxt_s;
  logic              tx_en_r, tx_en_nxt_s;
  logic [2:0]        baud_r, baud_nxt_s;
  logic              timeout_r, timeout_nxt_s;

  logic [7:0]        data_arr_s [NREQ];
  logic [PW-1:0]     cand_s;
  logic [PW-1:0]     win_idx_s;
  logic              win_found_s;
  logic              start_s;
  logic              cont_s;
  logic              expired_s;
  logic              load_s;
  logic              release_s;
  logic [PW-1:0]     load_idx_s;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
    if (idx == PW'(NREQ - 1)) return {PW{1'b0}};
    else return idx + PW'(1);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr_s[g] = req_data[8*g +: 8];
  end

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PW{1'b0}};
    cand_s      = {PW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      cand_s = PW'((int'(ptr_r) + i) % NREQ);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign start_s   = tx_en_cfg & win_found_s & ~Tx_BUSY;
  assign cont_s    = ~last_r & req[winner_r] & tx_en_cfg & (cnt_r < 8'(MAX_BURST));
  assign expired_s = (timer_r == TW'(TIMEOUT - 1));

  // State and output register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= {PW{1'b0}};
      winner_r  <= {PW{1'b0}};
      cnt_r     <= 8'd0;
      timer_r   <= {TW{1'b0}};
      last_r    <= 1'b0;
      ack_r     <= {NREQ{1'b0}};
      grant_r   <= {NREQ{1'b0}};
      tx_data_r <= 8'd0;
      tx_wr_r   <= 1'b0;
      tx_en_r   <= 1'b0;
      baud_r    <= 3'd0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ptr_r     <= ptr_nxt_s;
      winner_r  <= winner_nxt_s;
      cnt_r     <= cnt_nxt_s;
      timer_r   <= timer_nxt_s;
      last_r    <= last_nxt_s;
      ack_r     <= ack_nxt_s;
      grant_r   <= grant_nxt_s;
      tx_data_r <= tx_data_nxt_s;
      tx_wr_r   <= tx_wr_nxt_s;
      tx_en_r   <= tx_en_nxt_s;
      baud_r    <= baud_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = WRITE;
        else         state_nxt_s = IDLE;
      end
      WRITE: state_nxt_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (Tx_BUSY)        state_nxt_s = WAIT_DONE;
        else if (expired_s) state_nxt_s = IDLE;
        else                state_nxt_s = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (Tx_BUSY)     state_nxt_s = WAIT_DONE;
        else if (cont_s) state_nxt_s = WRITE;
        else             state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    ack_nxt_s     = {NREQ{1'b0}};
    tx_wr_nxt_s   = 1'b0;
    grant_nxt_s   = grant_r;
    tx_data_nxt_s = tx_data_r;
    tx_en_nxt_s   = tx_en_r;
    baud_nxt_s    = baud_r;
    timeout_nxt_s = timeout_r;
    ptr_nxt_s     = ptr_r;
    winner_nxt_s  = winner_r;
    cnt_nxt_s     = cnt_r;
    timer_nxt_s   = timer_r;
    last_nxt_s    = last_r;
    load_s        = 1'b0;
    release_s     = 1'b0;
    load_idx_s    = winner_r;
    case (state_r)
      IDLE: begin
        // Config is only sampled here so a burst always runs on one setting.
        tx_en_nxt_s = tx_en_cfg;
        baud_nxt_s  = baud_cfg;
        if (start_s) begin
          load_s       = 1'b1;
          load_idx_s   = win_idx_s;
          winner_nxt_s = win_idx_s;
          grant_nxt_s  = onehot(win_idx_s);
          cnt_nxt_s    = 8'd1;
        end else begin
          load_s = 1'b0;
        end
      end
      WRITE: timer_nxt_s = {TW{1'b0}};
      WAIT_BUSY: begin
        if (Tx_BUSY) begin
          timer_nxt_s = timer_r;
        end else if (expired_s) begin
          timeout_nxt_s = 1'b1;
          release_s     = 1'b1;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (Tx_BUSY) begin
          load_s = 1'b0;
        end else if (cont_s) begin
          load_s    = 1'b1;
          cnt_nxt_s = cnt_r + 8'd1;
        end else begin
          release_s = 1'b1;
        end
      end
      default: release_s = 1'b1;
    endcase

    if (load_s) begin
      tx_data_nxt_s = data_arr_s[load_idx_s];
      tx_wr_nxt_s   = 1'b1;
      ack_nxt_s     = onehot(load_idx_s);
      last_nxt_s    = req_last[load_idx_s];
    end else begin
      tx_wr_nxt_s = 1'b0;
    end

    // The pointer only moves past the owner when its grant is given up.
    if (release_s) begin
      grant_nxt_s = {NREQ{1'b0}};
      ptr_nxt_s   = wrap_inc(winner_r);
      cnt_nxt_s   = 8'd0;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  assign ack         = ack_r;
  assign grant       = grant_r;
  assign Tx_DATA     = tx_data_r;
  assign Tx_WR       = tx_wr_r;
  assign Tx_EN       = tx_en_r;
  assign baud_select = baud_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected writes are queued with the
// stimulus, a monitor pops one entry per Tx_WR and compares it.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 8;
  localparam int FRAME     = 5;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic [2:0]        baud_cfg;
  logic              tx_en_cfg;
  logic [7:0]        Tx_DATA;
  logic              Tx_WR;
  logic              Tx_EN;
  logic [2:0]        baud_select;
  logic              Tx_BUSY;
  logic              timeout_err;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
    logic [2:0] b;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] rq [NREQ][$];
  logic       tx_dead;
  int         checks = 0;
  int         errors = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .baud_cfg(baud_cfg), .tx_en_cfg(tx_en_cfg),
    .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .baud_select(baud_select),
    .Tx_BUSY(Tx_BUSY), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_wr(input logic [3:0] g, input logic [7:0] d, input logic [2:0] b);
    exp_q.push_back('{g: g, d: d, b: b});
  endtask

  task automatic give(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
  endtask

  // Transmitter model: busy one cycle after each write, for FRAME cycles.
  initial begin
    Tx_BUSY = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (Tx_WR && !tx_dead) begin
        @(posedge clk); #1;
        Tx_BUSY = 1'b1;
        repeat (FRAME) @(posedge clk);
        #1;
        Tx_BUSY = 1'b0;
      end
    end
  end

  // Requester model: present the head byte, pop it on ack.
  initial begin
    req = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() > 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every write is matched against the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && Tx_WR) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'd0, Tx_DATA}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_grant", {28'd0, grant}, {28'd0, e.g});
          chk("wr_ack", {28'd0, ack}, {28'd0, e.g});
          chk("wr_data", {24'd0, Tx_DATA}, {24'd0, e.d});
          chk("wr_baud", {29'd0, baud_select}, {29'd0, e.b});
          chk("wr_tx_en", {31'd0, Tx_EN}, 32'd1);
          chk("wr_while_busy", {31'd0, Tx_BUSY}, 32'd0);
        end
      end else if (!reset && ack != '0) begin
        chk("ack_without_wr", {28'd0, ack}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant != '0 || Tx_BUSY ||
            rq[0].size() != 0 || rq[1].size() != 0 ||
            rq[2].size() != 0 || rq[3].size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_time"}, (n < 400) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sig(input string name, input int which);
    int n;
    n = 0;
    while (n < 100 && !((which == 0 && Tx_WR) || (which == 1 && Tx_BUSY) ||
                        (which == 2 && !Tx_BUSY) || (which == 3 && ack[0]))) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_seen"}, (n < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; tx_dead = 1'b0; baud_cfg = 3'd7; tx_en_cfg = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_wr", {31'd0, Tx_WR}, 32'd0);
    chk("rst_tx_data", {24'd0, Tx_DATA}, 32'd0);
    chk("rst_tx_en", {31'd0, Tx_EN}, 32'd0);
    chk("rst_baud", {29'd0, baud_select}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: write one cycle after req is sampled, release after frame.
    @(posedge clk);
    expect_wr(4'b0001, 8'hA5, 3'd7);
    give(0, 8'hA5, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_latency_wr", {31'd0, Tx_WR}, 32'd1);
    @(negedge clk);
    chk("t1_wr_one_cycle", {31'd0, Tx_WR}, 32'd0);
    wait_sig("t1_busy_rise", 1);
    wait_sig("t1_busy_fall", 2);
    chk("t1_grant_held", {28'd0, grant}, 32'b0001);
    @(negedge clk);
    chk("t1_grant_released", {28'd0, grant}, 32'd0);
    wait_idle("t1");

    // All four requesting: 0,1,2,3 then 0 again.
    do_reset();
    @(posedge clk);
    expect_wr(4'b0001, 8'h10, 3'd7);
    expect_wr(4'b0010, 8'h20, 3'd7);
    expect_wr(4'b0100, 8'h30, 3'd7);
    expect_wr(4'b1000, 8'h40, 3'd7);
    expect_wr(4'b0001, 8'h11, 3'd7);
    give(0, 8'h10, 1'b1); give(0, 8'h11, 1'b1);
    give(1, 8'h20, 1'b1); give(2, 8'h30, 1'b1); give(3, 8'h40, 1'b1);
    wait_idle("t2");

    // Burst of three ending on last, then an unbounded burst cut at MAX_BURST.
    do_reset();
    @(posedge clk);
    expect_wr(4'b0001, 8'h11, 3'd7);
    expect_wr(4'b0001, 8'h22, 3'd7);
    expect_wr(4'b0001, 8'h33, 3'd7);
    expect_wr(4'b0010, 8'h44, 3'd7);
    give(0, 8'h11, 1'b0); give(0, 8'h22, 1'b0); give(0, 8'h33, 1'b1);
    give(1, 8'h44, 1'b1);
    wait_idle("t3a");
    do_reset();
    @(posedge clk);
    expect_wr(4'b0001, 8'h51, 3'd7);
    expect_wr(4'b0001, 8'h52, 3'd7);
    expect_wr(4'b0001, 8'h53, 3'd7);
    expect_wr(4'b0001, 8'h54, 3'd7);
    expect_wr(4'b0010, 8'h66, 3'd7);
    expect_wr(4'b0001, 8'h55, 3'd7);
    for (int i = 0; i < 5; i++) give(0, 8'h51 + 8'(i), 1'b0);
    give(1, 8'h66, 1'b1);
    wait_idle("t3b");

    // Dead transmitter: timeout, release, pointer moves past requester 0.
    do_reset();
    tx_dead = 1'b1;
    @(posedge clk);
    expect_wr(4'b0001, 8'hC3, 3'd7);
    give(0, 8'hC3, 1'b1);
    wait_sig("t4_wr", 0);
    k = 0;
    while (!timeout_err && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t4_timeout_latency", k, TIMEOUT + 1);
    chk("t4_grant_dropped", {28'd0, grant}, 32'd0);
    tx_dead = 1'b0;
    wait_idle("t4a");
    @(posedge clk);
    expect_wr(4'b0010, 8'hD4, 3'd7);
    expect_wr(4'b0001, 8'hE5, 3'd7);
    give(0, 8'hE5, 1'b1); give(1, 8'hD4, 1'b1);
    wait_idle("t4b");
    chk("t4_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Baud change mid-burst takes effect only once idle.
    do_reset();
    @(posedge clk);
    expect_wr(4'b0001, 8'hA1, 3'd7);
    expect_wr(4'b0001, 8'hA2, 3'd7);
    expect_wr(4'b0001, 8'hA3, 3'd7);
    give(0, 8'hA1, 1'b0); give(0, 8'hA2, 1'b0); give(0, 8'hA3, 1'b1);
    wait_sig("t5_first_ack", 3);
    baud_cfg = 3'd3;
    @(negedge clk);
    chk("t5_baud_held", {29'd0, baud_select}, 32'd7);
    wait_idle("t5a");
    chk("t5_baud_idle", {29'd0, baud_select}, 32'd3);
    @(posedge clk);
    expect_wr(4'b0010, 8'hB1, 3'd3);
    give(1, 8'hB1, 1'b1);
    wait_idle("t5b");

    // Reset in WAIT_DONE aborts; the pending byte is sent afterwards.
    baud_cfg = 3'd7;
    do_reset();
    @(posedge clk);
    expect_wr(4'b0001, 8'hF0, 3'd7);
    expect_wr(4'b0001, 8'hF1, 3'd7);
    give(0, 8'hF0, 1'b0); give(0, 8'hF1, 1'b1);
    wait_sig("t6_busy", 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chk("t6_ack", {28'd0, ack}, 32'd0);
    chk("t6_tx_wr", {31'd0, Tx_WR}, 32'd0);
    chk("t6_tx_data", {24'd0, Tx_DATA}, 32'd0);
    chk("t6_tx_en", {31'd0, Tx_EN}, 32'd0);
    chk("t6_baud", {29'd0, baud_select}, 32'd0);
    reset = 1'b0;
    wait_idle("t6");

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
